// File: rtl/l2_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_ctrl_pkg
// Purpose  : Shared definitions for the L2 access controller: controller
//            state encodings, requester id constants and the miss fill
//            pattern returned by L2 models.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package l2_ctrl_pkg;

    // Controller states with fixed encodings
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_LOOKUP    = 2'd2,
        ST_MISS_WAIT = 2'd3
    } state_t;

    // Requester ids as carried on resp_id
    localparam logic c_PORT_I = 1'b0;
    localparam logic c_PORT_D = 1'b1;

    // Word an L2 model returns on a miss (fill)
    localparam logic [31:0] c_L2_FILL_PATTERN = 32'hDEAD_BEEF;

    // Width of the miss penalty down-counter (MISS_PENALTY <= 255)
    localparam int c_PENALTY_W = 8;

endpackage : l2_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin arbiter. A lone valid is always granted;
//            when both are valid the pointer chooses. On i_advance the
//            pointer moves to the port that was not granted.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_valid[1:0]  - request valids
//            i_advance     - the current grant was accepted this cycle
//            o_grant[1:0]  - one-hot grant (zero when nothing is valid)
//            o_grant_id    - index of the granted port
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    logic r_ptr;
    logic w_grant_id;

    always_comb begin
        w_grant_id = 1'b0;
        case (i_valid)
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = r_ptr;
            default: w_grant_id = 1'b0;
        endcase
    end

    assign o_grant_id = w_grant_id;
    assign o_grant    = (i_valid == 2'b00) ? 2'b00 :
                        (w_grant_id ? 2'b10 : 2'b01);

    // Pointer names the port that wins the next tie; it always moves away
    // from the port just served so a continuously requesting pair alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~w_grant_id;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/l2_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l2_access_ctrl
// Purpose  : Front-end controller for the 4-way set-associative L2 read
//            cache. Arbitrates two L1-side requesters, sequences each request
//            through issue / lookup / modelled miss penalty, returns tagged
//            responses and keeps saturating hit/miss statistics.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req0_* / req1_*          - I-side / D-side request handshake
//            resp_valid/id/data/hit   - response pulse and held payload
//            l2_read, l2_addr         - read strobe and address to the L2
//            l2_hit, l2_read_data     - L2 result, valid the cycle after read
//            hit_count, miss_count    - saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module l2_access_ctrl
    import l2_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int MISS_PENALTY = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  resp_valid,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic                  l2_read,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    input  logic                  l2_hit,
    input  logic [DATA_WIDTH-1:0] l2_read_data,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    // The counter is loaded in LOOKUP and reaches zero in the last
    // MISS_WAIT cycle, giving exactly MISS_PENALTY cycles of wait.
    localparam logic [c_PENALTY_W-1:0] c_PENALTY_INIT = c_PENALTY_W'(MISS_PENALTY - 1);
    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE      = CNT_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_PENALTY_W-1:0]  r_penalty;
    logic                    r_id;
    logic [DATA_WIDTH-1:0]   r_fill;
    logic                    r_resp_valid;
    logic                    r_resp_id;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic                    r_resp_hit;
    logic                    r_l2_read;
    logic [ADDR_WIDTH-1:0]   r_l2_addr;
    logic [CNT_WIDTH-1:0]    r_hit_count;
    logic [CNT_WIDTH-1:0]    r_miss_count;

    logic                    w_idle;
    logic                    w_accept;
    logic [1:0]              w_grant;
    logic                    w_grant_id;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;

    // ------------------------------------------------------------------
    // Arbitration / acceptance
    // ------------------------------------------------------------------
    assign w_idle = (r_state == ST_IDLE);

    // Acceptance is suppressed during reset so nothing is taken on a cycle
    // whose state update is about to be discarded.
    assign w_accept = w_idle & ~rst & (req0_valid | req1_valid);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_valid    ({req1_valid, req0_valid}),
        .i_advance  (w_accept),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign req0_ready = w_accept & w_grant[0];
    assign req1_ready = w_accept & w_grant[1];
    assign w_sel_addr = w_grant_id ? req1_addr : req0_addr;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                w_state_nxt = l2_hit ? ST_IDLE : ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (r_penalty == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, response and statistics registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_penalty    <= '0;
            r_id         <= 1'b0;
            r_fill       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_hit   <= 1'b0;
            r_l2_read    <= 1'b0;
            r_l2_addr    <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id      <= w_grant_id;
                        r_l2_read <= 1'b1;
                        r_l2_addr <= w_sel_addr;
                    end
                end
                ST_ISSUE: begin
                    r_l2_read <= 1'b0;
                end
                ST_LOOKUP: begin
                    // The only cycle in which the L2 result is meaningful.
                    if (l2_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_id    <= r_id;
                        r_resp_data  <= l2_read_data;
                        if (r_hit_count != '1) begin
                            r_hit_count <= r_hit_count + c_CNT_ONE;
                        end
                    end else begin
                        r_fill    <= l2_read_data;
                        r_penalty <= c_PENALTY_INIT;
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + c_CNT_ONE;
                        end
                    end
                end
                ST_MISS_WAIT: begin
                    if (r_penalty == '0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b0;
                        r_resp_id    <= r_id;
                        r_resp_data  <= r_fill;
                    end else begin
                        r_penalty <= r_penalty - 1'b1;
                    end
                end
                default: begin
                    r_l2_read <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_hit   = r_resp_hit;
    assign l2_read    = r_l2_read;
    assign l2_addr    = r_l2_addr;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule : l2_access_ctrl
`default_nettype wire

// File: tb/tb_l2_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_access_ctrl
// Purpose  : Directed self-checking bench for l2_access_ctrl with a simple
//            L2 model (hit if the address was read before, fill pattern as
//            data, stale garbage outside the result cycle).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_access_ctrl;
    import l2_ctrl_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready;
    logic          resp_valid, resp_id, resp_hit;
    logic [DW-1:0] resp_data;
    logic          l2_read;
    logic [AW-1:0] l2_addr;
    logic          l2_hit;
    logic [DW-1:0] l2_read_data;
    logic [CW-1:0] hit_count, miss_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_access_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MISS_PENALTY (8),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_ready   (req1_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_data    (resp_data),
        .resp_hit     (resp_hit),
        .l2_read      (l2_read),
        .l2_addr      (l2_addr),
        .l2_hit       (l2_hit),
        .l2_read_data (l2_read_data),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    // L2 model: result valid only in the cycle after l2_read; otherwise it
    // shows a stale hit with garbage data.
    logic cached [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) cached[i] = 1'b0;
        l2_hit       = 1'b0;
        l2_read_data = '0;
    end
    always @(posedge clk) begin
        if (l2_read) begin
            l2_hit       <= cached[l2_addr];
            l2_read_data <= c_L2_FILL_PATTERN;
            cached[l2_addr] <= 1'b1;
        end else begin
            l2_hit       <= 1'b1;
            l2_read_data <= 32'h0BAD_0BAD;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present a request at the current negedge, wait for acceptance, then
    // wait for the response. lat counts cycles from the accept cycle (0).
    task automatic send(input int port, input logic [AW-1:0] addr, input string tag,
                        output int lat, output logic o_hit,
                        output logic [DW-1:0] o_data, output logic o_id);
        int w;
        if (port == 0) begin req0_valid = 1'b1; req0_addr = addr; end
        else           begin req1_valid = 1'b1; req1_addr = addr; end
        #1;
        w = 0;
        while (!(port == 0 ? req0_ready : req1_ready) && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk({tag, "_accept"}, port == 0 ? req0_ready : req1_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_resp_seen"}, resp_valid, 1);
        o_hit  = resp_hit;
        o_data = resp_data;
        o_id   = resp_id;
    endtask

    initial begin
        int            n, lat, g, overlap, pulses, first;
        logic          h, id;
        logic [DW-1:0] d;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr  = '0;   req1_addr  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data",  resp_data, 0);
        chk("rst_l2_read",    l2_read, 0);
        chk("rst_counts",     {hit_count, miss_count}, 0);
        rst = 1'b0;

        // 1. Cold miss
        req0_valid = 1'b1; req0_addr = 11'h040;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t1_l2_read_c1", l2_read, 1);
        chk("t1_l2_addr_c1", l2_addr, 11'h040);
        @(negedge clk);
        chk("t1_l2_read_c2", l2_read, 0);
        n = 2;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        chk("t1_resp_cycle", n, 11);
        chk("t1_resp_id",    resp_id, 0);
        chk("t1_resp_hit",   resp_hit, 0);
        chk("t1_resp_data",  resp_data, 32'hDEAD_BEEF);
        chk("t1_miss_count", miss_count, 1);
        chk("t1_hit_count",  hit_count, 0);
        @(negedge clk);
        chk("t1_pulse_end",  resp_valid, 0);
        chk("t1_data_hold",  resp_data, 32'hDEAD_BEEF);

        // 2. Warm hit
        send(0, 11'h040, "t2", lat, h, d, id);
        chk("t2_latency",   lat, 3);
        chk("t2_resp_hit",  h, 1);
        chk("t2_resp_data", d, 32'hDEAD_BEEF);
        chk("t2_resp_id",   id, 0);
        chk("t2_hit_count", hit_count, 1);
        chk("t2_miss_count", miss_count, 1);

        // 3. Contention after reset: port 0 (hit) then port 1 (miss)
        do_reset();
        req0_valid = 1'b1; req0_addr = 11'h040;
        req1_valid = 1'b1; req1_addr = 11'h080;
        #1;
        chk("t3_ready0_c0", req0_ready, 1);
        chk("t3_ready1_c0", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t3_ready1_c1", req1_ready, 0);
        @(negedge clk);
        chk("t3_ready1_c2", req1_ready, 0);
        @(negedge clk);
        chk("t3_resp0_valid", resp_valid, 1);
        chk("t3_resp0_id",    resp_id, 0);
        chk("t3_ready1_c3",   req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        n = 4;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        chk("t3_resp1_cycle", n, 14);
        chk("t3_resp1_id",    resp_id, 1);
        chk("t3_resp1_hit",   resp_hit, 0);

        // 4. Fairness: both ports hold valid for six hits
        do_reset();
        req0_valid = 1'b1; req0_addr = 11'h040;
        req1_valid = 1'b1; req1_addr = 11'h040;
        g = 0; overlap = 0; n = 0;
        while (g < 6 && n < 60) begin
            #1;
            if (req0_ready && req1_ready) overlap++;
            if (req0_ready || req1_ready) begin
                chk($sformatf("t4_grant%0d", g), req1_ready, g % 2);
                g++;
            end
            @(negedge clk);
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t4_grants",  g, 6);
        chk("t4_overlap", overlap, 0);
        repeat (3) @(negedge clk);
        chk("t4_hit_count", hit_count, 6);

        // 5. Reset in cycle 5 of a miss, req1 waiting
        do_reset();
        req0_valid = 1'b1; req0_addr = 11'h200;
        #1;
        chk("t5_ready0_c0", req0_ready, 1);
        pulses = 0;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 11'h040;
        for (int c = 1; c <= 4; c++) begin
            if (resp_valid) pulses++;
            @(negedge clk);
        end
        chk("t5_miss_before_rst", miss_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_resp_id",    resp_id, 0);
        chk("t5_resp_data",  resp_data, 0);
        chk("t5_resp_hit",   resp_hit, 0);
        chk("t5_l2_read",    l2_read, 0);
        chk("t5_l2_addr",    l2_addr, 0);
        chk("t5_counts",     {hit_count, miss_count}, 0);
        chk("t5_ready1_c6",  req1_ready, 1);
        chk("t5_ready0_c6",  req0_ready, 0);
        @(negedge clk);
        req1_valid = 1'b0;
        first = -1;
        for (int c = 7; c <= 20; c++) begin
            if (resp_valid) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    chk("t5_resp_id1",  resp_id, 1);
                    chk("t5_resp_hit1", resp_hit, 1);
                end
            end
            @(negedge clk);
        end
        chk("t5_resp_pulses", pulses, 1);
        chk("t5_resp_cycle",  first, 9);

        // 6. Saturation with 4-bit counters: 1 miss then 20 hits
        do_reset();
        send(0, 11'h300, "t6_miss", lat, h, d, id);
        chk("t6_miss_hit", h, 0);
        for (int i = 0; i < 20; i++) begin
            send(0, 11'h300, "t6_hit", lat, h, d, id);
            if (i == 14) chk("t6_hit_at_15", hit_count, 15);
        end
        chk("t6_hit_sat",   hit_count, 15);
        chk("t6_miss_keep", miss_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_l2_access_ctrl
`default_nettype wire
